stack_cpu: RTL and testbench

STACK_CPU -- requirements
Module: stack_cpu

---
 rtl/stack_cpu.sv | 188 ++++++++++++++++++
 tb/tb_stack_cpu.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_cpu.sv
// ============================================================================
// stack_cpu : multi-cycle stack machine sharing one ready/valid memory port.
// Optional macro STACK_CPU_UNDERFLOW_CHECK_EN traps pops from an empty stack.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module stack_cpu #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] STACK_START = '1,
  parameter logic [ADDR_W-1:0] ENTRY_POINT = 'h0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              halted,
  output logic              error
);

  localparam logic [5:0] c_op_nop   = 6'h00;
  localparam logic [5:0] c_op_pushi = 6'h01;
  localparam logic [5:0] c_op_drop  = 6'h02;
  localparam logic [5:0] c_op_add   = 6'h04;
  localparam logic [5:0] c_op_sub   = 6'h05;
  localparam logic [5:0] c_op_and   = 6'h06;
  localparam logic [5:0] c_op_or    = 6'h07;
  localparam logic [5:0] c_op_xor   = 6'h08;
  localparam logic [5:0] c_op_load  = 6'h09;
  localparam logic [5:0] c_op_store = 6'h0A;
  localparam logic [5:0] c_op_jmp   = 6'h0B;
  localparam logic [5:0] c_op_jz    = 6'h0C;
  localparam logic [5:0] c_op_halt  = 6'h3F;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_POP_B, S_POP_A, S_EXEC,
    S_MEMRD, S_MEMWR, S_PUSH, S_HALT, S_ERR
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_sp;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_r;

  logic [5:0]        w_op;
  logic [DATA_W-1:0] w_imm;
  logic [ADDR_W-1:0] w_sp_inc;
  logic [ADDR_W-1:0] w_sp_dec;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_access;
  logic              w_underflow;
  logic              w_done;
  logic [DATA_W-1:0] w_alu;

  assign w_op     = r_ir[DATA_W-1 -: 6];
  assign w_imm    = {6'b0, r_ir[DATA_W-7:0]};
  assign w_sp_inc = r_sp + ADDR_W'(1);
  assign w_sp_dec = r_sp - ADDR_W'(1);
  assign w_pc_inc = r_pc + ADDR_W'(1);

`ifdef STACK_CPU_UNDERFLOW_CHECK_EN
  assign w_underflow = ((r_state == S_POP_B) || (r_state == S_POP_A)) && (r_sp == STACK_START);
`else
  assign w_underflow = 1'b0;
`endif

  always_comb begin
    w_access = 1'b0;
    case (r_state)
      S_FETCH, S_POP_B, S_POP_A, S_MEMRD, S_MEMWR, S_PUSH: w_access = 1'b1;
      default:                                             w_access = 1'b0;
    endcase
  end

  // Reset gates the request combinationally so a stalled access is dropped at once.
  assign mem_req   = w_access && !w_underflow && !rst;
  assign w_done    = mem_req && mem_ready;
  assign mem_we    = (r_state == S_MEMWR) || (r_state == S_PUSH);
  assign mem_wdata = (r_state == S_MEMWR) ? r_a : r_r;
  assign halted    = (r_state == S_HALT);
  assign error     = (r_state == S_ERR);

  always_comb begin
    mem_addr = r_pc;
    case (r_state)
      S_POP_B, S_POP_A: mem_addr = w_sp_inc;
      S_MEMRD, S_MEMWR: mem_addr = r_b[ADDR_W-1:0];
      S_PUSH:           mem_addr = r_sp;
      default:          mem_addr = r_pc;
    endcase
  end

  always_comb begin
    w_alu = r_a + r_b;
    case (w_op)
      c_op_sub: w_alu = r_a - r_b;
      c_op_and: w_alu = r_a & r_b;
      c_op_or:  w_alu = r_a | r_b;
      c_op_xor: w_alu = r_a ^ r_b;
      default:  w_alu = r_a + r_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= ENTRY_POINT;
      r_sp    <= STACK_START;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (w_done) begin
          r_ir    <= mem_rdata;
          r_pc    <= w_pc_inc;
          r_state <= S_DECODE;
        end
        S_DECODE: case (w_op)
          c_op_nop:   r_state <= S_FETCH;
          c_op_pushi: begin
            r_r     <= w_imm;
            r_state <= S_PUSH;
          end
          c_op_drop, c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor,
          c_op_load, c_op_store, c_op_jmp, c_op_jz: r_state <= S_POP_B;
          c_op_halt:  r_state <= S_HALT;
          default:    r_state <= S_ERR;
        endcase
        S_POP_B: if (w_underflow) begin
          r_state <= S_ERR;
        end else if (w_done) begin
          r_b  <= mem_rdata;
          r_sp <= w_sp_inc;
          case (w_op)
            c_op_drop: r_state <= S_FETCH;
            c_op_load: r_state <= S_MEMRD;
            c_op_jmp:  r_state <= S_EXEC;
            default:   r_state <= S_POP_A;
          endcase
        end
        S_POP_A: if (w_underflow) begin
          r_state <= S_ERR;
        end else if (w_done) begin
          r_a     <= mem_rdata;
          r_sp    <= w_sp_inc;
          r_state <= (w_op == c_op_store) ? S_MEMWR : S_EXEC;
        end
        S_EXEC: case (w_op)
          c_op_jmp: begin
            r_pc    <= r_b[ADDR_W-1:0];
            r_state <= S_FETCH;
          end
          c_op_jz: begin
            if (r_b == '0) r_pc <= r_a[ADDR_W-1:0];
            r_state <= S_FETCH;
          end
          default: begin
            r_r     <= w_alu;
            r_state <= S_PUSH;
          end
        endcase
        S_MEMRD: if (w_done) begin
          r_r     <= mem_rdata;
          r_state <= S_PUSH;
        end
        S_MEMWR: if (w_done) r_state <= S_FETCH;
        S_PUSH: if (w_done) begin
          r_sp    <= w_sp_dec;
          r_state <= S_FETCH;
        end
        default: r_state <= r_state;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stack_cpu.sv
// ============================================================================
// tb_stack_cpu : scoreboard bench for stack_cpu against an instruction-level model.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_stack_cpu;

  logic        clk;
  logic        rst;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        halted;
  logic        error;

  stack_cpu dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .halted    (halted),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
  } acc_t;

  logic [15:0] mem [0:65535];
  logic [15:0] mm  [0:65535];
  acc_t        exp_q [$];

  int checks    = 0;
  int failures  = 0;
  int stall_cnt = 0;
  int wait_mode = 0;
  int cur_wait  = 0;
  int wcnt      = 0;

  logic [15:0] m_pc, m_sp;
  int          m_cyc, m_nacc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk)
    if (mem_req && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;

  function automatic int pick();
    if (wait_mode == 0) return 0;
    if (wait_mode == 1) return 3;
    return int'($urandom_range(0, 3));
  endfunction

  // Ready driver: inserts cur_wait low cycles before each completion.
  always @(posedge clk) begin
    #3;
    if (rst) begin
      mem_ready = 1'b0; wcnt = 0; cur_wait = pick();
    end else if (!mem_req) begin
      mem_ready = 1'b0;
    end else if (wcnt < cur_wait) begin
      mem_ready = 1'b0; wcnt++;
    end else begin
      mem_ready = 1'b1; wcnt = 0; cur_wait = pick();
    end
  end

  // Monitor: every completed access is matched against the scoreboard.
  logic        h_valid = 1'b0;
  logic [32:0] h_bus;
  always @(negedge clk) begin
    acc_t e;
    if (rst) begin
      h_valid = 1'b0;
    end else begin
      if (mem_req && h_valid) chk("stall_bus_stable", {mem_addr, mem_we, mem_wdata}, h_bus);
      if (mem_req && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_access actual addr=%h we=%b required=none", mem_addr, mem_we);
        end else begin
          e = exp_q.pop_front();
          chk("acc_addr", mem_addr, e.addr);
          chk("acc_we", mem_we, e.we);
          if (e.we) chk("acc_wdata", mem_wdata, e.data);
        end
      end
      if (mem_req && !mem_ready) stall_cnt++;
      h_valid = mem_req && !mem_ready;
      h_bus   = {mem_addr, mem_we, mem_wdata};
    end
  end

  task automatic exp_push(input logic [15:0] a, input logic w, input logic [15:0] d);
    acc_t e;
    e.addr = a; e.we = w; e.data = d;
    exp_q.push_back(e);
    m_nacc++;
  endtask

  task automatic mpop(output logic [15:0] v, output bit uf);
    uf = 1'b0; v = '0;
`ifdef STACK_CPU_UNDERFLOW_CHECK_EN
    if (m_sp == 16'hFFFF) begin uf = 1'b1; m_cyc++; return; end
`endif
    m_sp = m_sp + 16'd1;
    v = mm[m_sp];
    exp_push(m_sp, 1'b0, v);
    m_cyc++;
  endtask

  task automatic mpush(input logic [15:0] v);
    mm[m_sp] = v;
    exp_push(m_sp, 1'b1, v);
    m_sp = m_sp - 16'd1;
    m_cyc++;
  endtask

  // Instruction-level reference: walks the program, records every access and the cycle cost.
  task automatic model_run(output bit eh, output bit ee);
    logic [15:0] ir, a, b, r;
    bit uf, done;
    m_pc = 16'h0020; m_sp = 16'hFFFF; m_cyc = 0; m_nacc = 0;
    eh = 0; ee = 0; done = 0;
    for (int n = 0; n < 4000 && !done; n++) begin
      ir = mm[m_pc];
      exp_push(m_pc, 1'b0, ir);
      m_pc = m_pc + 16'd1;
      m_cyc += 2;
      a = '0; b = '0; uf = 0;
      case (ir[15:10])
        6'h00: ;
        6'h01: mpush({6'd0, ir[9:0]});
        6'h02: mpop(b, uf);
        6'h04, 6'h05, 6'h06, 6'h07, 6'h08: begin
          mpop(b, uf);
          if (!uf) mpop(a, uf);
          if (!uf) begin
            m_cyc++;
            case (ir[15:10])
              6'h04:   r = a + b;
              6'h05:   r = a - b;
              6'h06:   r = a & b;
              6'h07:   r = a | b;
              default: r = a ^ b;
            endcase
            mpush(r);
          end
        end
        6'h09: begin
          mpop(b, uf);
          if (!uf) begin
            r = mm[b]; exp_push(b, 1'b0, r); m_cyc++;
            mpush(r);
          end
        end
        6'h0A: begin
          mpop(b, uf);
          if (!uf) mpop(a, uf);
          if (!uf) begin mm[b] = a; exp_push(b, 1'b1, a); m_cyc++; end
        end
        6'h0B: begin
          mpop(b, uf);
          if (!uf) begin m_cyc++; m_pc = b; end
        end
        6'h0C: begin
          mpop(b, uf);
          if (!uf) mpop(a, uf);
          if (!uf) begin m_cyc++; if (b == 16'd0) m_pc = a; end
        end
        6'h3F: begin eh = 1; done = 1; end
        default: begin ee = 1; done = 1; end
      endcase
      if (uf) begin ee = 1; done = 1; end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; mm[i] = '0; end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem[a] = d; mm[a] = d;
  endtask

  task automatic load_add_prog();
    clear_mem();
    wr(16'h0020, 16'h0405); wr(16'h0021, 16'h0403);
    wr(16'h0022, 16'h1000); wr(16'h0023, 16'hFC00);
  endtask

  task automatic run_prog(input int wmode, output int cyc);
    bit eh, ee, done, anyreq;
    int bad;
    rst = 1'b1; wait_mode = wmode;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_error", error, 1'b0);
    exp_q.delete();
    stall_cnt = 0;
    model_run(eh, ee);
    rst = 1'b0;
    cyc = 0; done = 0;
    while (!done && cyc < 20000) begin
      @(posedge clk); #4;
      cyc++;
      if (halted || error) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL run_timeout actual=running required=terminal");
    end
    chk("final_halted", halted, eh);
    chk("final_error", error, ee);
    chk("cycle_count", cyc, m_cyc + stall_cnt);
    if (wmode == 1) chk("fixed_wait_stalls", stall_cnt, 3 * m_nacc);
    chk("accesses_left", exp_q.size(), 0);
    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== mm[i]) bad++;
    chk("memory_image", bad, 0);
    anyreq = 0;
    repeat (3) begin @(posedge clk); #4; if (mem_req) anyreq = 1; end
    chk("terminal_no_req", anyreq, 1'b0);
  endtask

  task automatic gen_random();
    logic [15:0] p;
    int depth, k;
    logic c;
    p = 16'h0020; depth = 0;
    clear_mem();
    for (int i = 0; i < 16; i++) wr(16'h0200 + 16'(i), 16'($urandom));
    for (int n = 0; n < 25; n++) begin
      k = int'($urandom_range(0, 7));
      case (k)
        0: if (depth < 16) begin wr(p, {6'd1, 10'($urandom)}); p++; depth++; end
        1: if (depth >= 2) begin wr(p, {6'($urandom_range(4, 8)), 10'd0}); p++; depth--; end
        2: if (depth >= 1) begin wr(p, 16'h0800); p++; depth--; end
        3: if (depth >= 1) begin
          wr(p, {6'd1, 10'h200 + 10'($urandom_range(0, 15))}); wr(p + 1, 16'h2800);
          p += 2; depth--;
        end
        4: if (depth < 16) begin
          wr(p, {6'd1, 10'h200 + 10'($urandom_range(0, 15))}); wr(p + 1, 16'h2400);
          p += 2; depth++;
        end
        5: if (depth < 16) begin
          c = 1'($urandom_range(0, 1));
          wr(p, {6'd1, 10'(p + 4)}); wr(p + 1, {6'd1, 9'd0, c});
          wr(p + 2, 16'h3000); wr(p + 3, {6'd1, 10'($urandom)});
          p += 4; depth += int'(c);
        end
        6: begin
          wr(p, {6'd1, 10'(p + 3)}); wr(p + 1, 16'h2C00); wr(p + 2, 16'h8000);
          p += 3;
        end
        default: begin wr(p, 16'h0000); p++; end
      endcase
    end
    wr(p, 16'hFC00);
  endtask

  initial begin
    int c;
    bit found;
    rst = 1'b1; mem_ready = 1'b0;

    load_add_prog();
    run_prog(0, c);
    chk("add_prog_cycles", c, 14);
    chk("add_prog_result", mem[16'hFFFF], 16'h0008);

    load_add_prog();
    run_prog(1, c);
    chk("add_prog_wait_cycles", c, 41);
    chk("add_prog_wait_result", mem[16'hFFFF], 16'h0008);

    clear_mem();
    wr(16'h0020, 16'h0403); wr(16'h0021, 16'h0405); wr(16'h0022, 16'h1400);
    wr(16'h0023, 16'h0440); wr(16'h0024, 16'h0400); wr(16'h0025, 16'h3000);
    wr(16'h0026, 16'h8000); wr(16'h0040, 16'hFC00);
    run_prog(0, c);
    chk("sub_result", mem[16'hFFFF], 16'hFFFE);
    chk("jz_taken_halt", halted, 1'b1);

    clear_mem();
    wr(16'h0020, 16'h8000);
    run_prog(0, c);
    chk("illegal_op_error", error, 1'b1);
    load_add_prog();
    run_prog(2, c);
    chk("after_error_rerun", mem[16'hFFFF], 16'h0008);

    clear_mem();
    wr(16'h0020, 16'h0800); wr(16'h0021, 16'h0409); wr(16'h0022, 16'hFC00);
    run_prog(0, c);
`ifdef STACK_CPU_UNDERFLOW_CHECK_EN
    chk("underflow_error", error, 1'b1);
`else
    chk("underflow_wrap_push", mem[16'h0000], 16'h0009);
`endif

    clear_mem();
    wr(16'h0020, 16'h0407); wr(16'h0021, 16'hFC00); wr(16'hFFFF, 16'h1234);
    rst = 1'b1; wait_mode = 1;
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete();
    begin
      bit eh, ee;
      model_run(eh, ee);
    end
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #4;
      if (mem_req && mem_we && !mem_ready) found = 1;
    end
    chk("stalled_push_seen", found, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_mem_req", mem_req, 1'b0);
    @(posedge clk); #4;
    chk("abort_no_write", mem[16'hFFFF], 16'h1234);
    mm[16'hFFFF] = 16'h1234;
    run_prog(0, c);
    chk("after_abort_push", mem[16'hFFFF], 16'h0007);

    for (int r = 0; r < 8; r++) begin
      gen_random();
      run_prog(r % 3, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
